// File: rtl/reg_write_arbiter.sv
// Two-requester register-bank write-back arbiter with registered write port and busy tracking.
// Define RR_ARB_EN for round-robin conflict resolution; otherwise the load unit (B) always wins.
module reg_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        A_Valid,
    input  logic [4:0]  A_Reg,
    input  logic [31:0] A_Data,
    output logic        A_Ready,
    input  logic        B_Valid,
    input  logic [4:0]  B_Reg,
    input  logic [31:0] B_Data,
    output logic        B_Ready,
    output logic        RegWrite,
    output logic [4:0]  Write_Reg,
    output logic [31:0] Write_Data,
    output logic [31:0] Busy_Mask,
    output logic [7:0]  Conflict_Cnt
);

    typedef enum logic {PriA, PriB} ptr_e;

    ptr_e        ptr_q, ptr_d;
    logic        conflict;
    logic        grant_a, grant_b;
    logic        reg_write_q;
    logic [4:0]  write_reg_q;
    logic [31:0] write_data_q;
    logic [7:0]  conflict_cnt_q;
    logic [31:0] busy_mask;

    assign conflict = A_Valid & B_Valid;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        ptr_d   = ptr_q;
        if (!rst) begin
            if (conflict) begin
`ifdef RR_ARB_EN
                // The loser of a conflict gets priority next time.
                if (ptr_q == PriA) begin
                    grant_a = 1'b1;
                    ptr_d   = PriB;
                end else begin
                    grant_b = 1'b1;
                    ptr_d   = PriA;
                end
`else
                grant_b = 1'b1;
`endif
            end else begin
                grant_a = A_Valid;
                grant_b = B_Valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q          <= PriA;
            reg_write_q    <= 1'b0;
            write_reg_q    <= 5'd0;
            write_data_q   <= 32'd0;
            conflict_cnt_q <= 8'd0;
        end else begin
            ptr_q       <= ptr_d;
            reg_write_q <= 1'b0;
            // Writes to r0 are consumed but never asserted on the bank.
            if (grant_a) begin
                reg_write_q  <= (A_Reg != 5'd0);
                write_reg_q  <= A_Reg;
                write_data_q <= A_Data;
            end else if (grant_b) begin
                reg_write_q  <= (B_Reg != 5'd0);
                write_reg_q  <= B_Reg;
                write_data_q <= B_Data;
            end
            if (conflict && (conflict_cnt_q != 8'hff)) begin
                conflict_cnt_q <= conflict_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        if (A_Valid) busy_mask[A_Reg] = 1'b1;
        if (B_Valid) busy_mask[B_Reg] = 1'b1;
        if (reg_write_q && !rst) busy_mask[write_reg_q] = 1'b1;
        busy_mask[0] = 1'b0;
    end

    assign A_Ready      = grant_a;
    assign B_Ready      = grant_b;
    assign RegWrite     = reg_write_q;
    assign Write_Reg    = write_reg_q;
    assign Write_Data   = write_data_q;
    assign Busy_Mask    = busy_mask;
    assign Conflict_Cnt = conflict_cnt_q;

endmodule
